// File: rtl/pes_ram_port_arbiter.sv
// rtl/pes_ram_port_arbiter.sv - round-robin two-requester arbiter for a single-port synchronous RAM with clear sequencer
//
// Ports:
//   clk, rst_n                      clock; asynchronous active-low reset
//   req_x, we_x, addr_x, wdata_x    requester x access (x = a, b), qualified by req_x
//   gnt_x                           combinational accept; req_x & gnt_x at a rising edge takes the access
//   rvalid_x, rdata_x               one-cycle read-return pulse with registered read data
//   clr_start, clr_busy, clr_done   RAM clear sequence start, busy level, completion pulse
//   ram_en, ram_we, ram_addr,
//   ram_din                         registered RAM port strobes
//   ram_dout                        RAM read data, valid one cycle after a read strobe
module pes_ram_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Last counter value of the clear sweep; the extra MSB keeps the compare
  // independent of the address wrapping back to zero.
  localparam logic [AW:0] CLR_LAST = {1'b0, {AW{1'b1}}};

  state_t        state;
  logic          prio_b;    // 1: B wins the next contention
  logic [AW:0]   clr_cnt;
  // Read-tag pipeline, {valid, is_b}; stage 0 covers the RAM strobe cycle,
  // stage 1 the cycle in which ram_dout carries the data.
  logic [1:0]    tag0;
  logic [1:0]    tag1;

  logic          arb_open;
  logic          acc;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  // Clear has priority over requesters, so grants drop as soon as clr_start rises.
  assign arb_open  = (state == ARB) && !clr_start;
  assign gnt_a     = arb_open && req_a && (!req_b || !prio_b);
  assign gnt_b     = arb_open && req_b && (!req_a ||  prio_b);
  assign acc       = gnt_a || gnt_b;
  assign acc_we    = gnt_b ? we_b    : we_a;
  assign acc_addr  = gnt_b ? addr_b  : addr_a;
  assign acc_wdata = gnt_b ? wdata_b : wdata_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      prio_b   <= 1'b0;
      clr_cnt  <= '0;
      tag0     <= 2'b00;
      tag1     <= 2'b00;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      clr_done <= 1'b0;
      tag0     <= 2'b00;
      tag1     <= tag0;

      // Read returns keep draining in either state, so reads issued just
      // before a clear still complete.
      rvalid_a <= tag1[1] && !tag1[0];
      rvalid_b <= tag1[1] &&  tag1[0];
      if (tag1[1]) begin
        if (tag1[0]) begin
          rdata_b <= ram_dout;
        end else begin
          rdata_a <= ram_dout;
        end
      end

      case (state)
        ARB: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end else if (acc) begin
            ram_en   <= 1'b1;
            ram_we   <= acc_we;
            ram_addr <= acc_addr;
            if (acc_we) begin
              ram_din <= acc_wdata;
            end
            tag0   <= {!acc_we, gnt_b};
            prio_b <= gnt_a;
          end
        end
        CLEAR: begin
          ram_en   <= 1'b1;
          ram_we   <= 1'b1;
          ram_addr <= clr_cnt[AW-1:0];
          ram_din  <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
          // The final write and clr_done land in the same cycle, with the
          // arbiter already open again.
          if (clr_cnt == CLR_LAST) begin
            state    <= ARB;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_pes_ram_port_arbiter.sv
// tb/tb_pes_ram_port_arbiter.sv - self-checking bench for pes_ram_port_arbiter
module tb_pes_ram_port_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          clr_start, clr_busy, clr_done;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  pes_ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM, 1-cycle read latency, cleared while in reset.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: memory contents, who was granted last, expected RAM
  // strobes and a queue of read returns keyed by the edge they are due after.
  typedef struct {
    int            due;
    bit            is_b;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  int            last_winner;   // 1 = A, 2 = B
  int            edge_n;
  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  rd_t           rdq[$];

  task automatic model_reset();
    last_winner = 2;
    edge_n      = 0;
    rdq.delete();
    exp_en   = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
  endtask

  // One clock cycle: entered just after a falling edge, drives the inputs,
  // checks outputs against the model, takes the rising edge, returns at the
  // next falling edge.
  task automatic cycle(input bit ra, input bit rb, input bit wa, input bit wb,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                       input logic [DW-1:0] da, input logic [DW-1:0] db,
                       output bit oga, output bit ogb, output bit orva, output bit orvb,
                       output logic [DW-1:0] ord_a, output logic [DW-1:0] ord_b);
    bit            ea, eb, erva, ervb, w;
    logic [DW-1:0] erd_a, erd_b, d;
    logic [AW-1:0] a;
    erva = 1'b0;
    ervb = 1'b0;
    erd_a = '0;
    erd_b = '0;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    clr_start = 1'b0;
    #1;
    ea = ra && (!rb || last_winner == 2);
    eb = rb && (!ra || last_winner == 1);
    chk("model_gnt_a", gnt_a & req_a, ea);
    chk("model_gnt_b", gnt_b & req_b, eb);
    while (rdq.size() > 0 && rdq[0].due == edge_n) begin
      if (rdq[0].is_b) begin ervb = 1'b1; erd_b = rdq[0].data; end
      else             begin erva = 1'b1; erd_a = rdq[0].data; end
      void'(rdq.pop_front());
    end
    chk("model_rvalid_a", rvalid_a, erva);
    chk("model_rvalid_b", rvalid_b, ervb);
    if (erva) chk("model_rdata_a", rdata_a, erd_a);
    if (ervb) chk("model_rdata_b", rdata_b, erd_b);
    chk("model_ram_en", ram_en, exp_en);
    chk("model_ram_we", ram_we, exp_we);
    chk("model_ram_addr", ram_addr, exp_addr);
    if (exp_en && exp_we) chk("model_ram_din", ram_din, exp_din);
    oga = gnt_a & req_a;  ogb = gnt_b & req_b;
    orva = rvalid_a;      orvb = rvalid_b;
    ord_a = rdata_a;      ord_b = rdata_b;
    @(posedge clk);
    edge_n++;
    if (ea || eb) begin
      w = ea ? wa : wb;
      a = ea ? aa : ab;
      d = ea ? da : db;
      exp_en = 1'b1;
      exp_we = w;
      exp_addr = a;
      if (w) begin
        exp_din = d;
        mdl_mem[a] = d;
      end else begin
        rdq.push_back('{edge_n + 2, eb, mdl_mem[a]});
      end
      last_winner = ea ? 1 : 2;
    end else begin
      exp_en = 1'b0;
      exp_we = 1'b0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit            ra, rb, wa, wb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    bit            ga, gb, rva, rvb;
    logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mk(int ra, int rb, int wa, int wb, int aa, int ab, int da, int db,
                              int ga, int gb, int rva, int rvb, int rd);
    vec_t v;
    v.ra = ra[0]; v.rb = rb[0]; v.wa = wa[0]; v.wb = wb[0];
    v.aa = aa[AW-1:0]; v.ab = ab[AW-1:0];
    v.da = da[DW-1:0]; v.db = db[DW-1:0];
    v.ga = ga[0]; v.gb = gb[0]; v.rva = rva[0]; v.rvb = rvb[0];
    v.rd = rd[DW-1:0];
    return v;
  endfunction

  initial begin
    vec_t          vt[21];
    bit            oga, ogb, orva, orvb;
    logic [DW-1:0] ord_a, ord_b;
    bit            ra, rb, wa, wb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    int n_gnt0, n_busy, n_done, done_at, gnt_at, n_wr, wr_bad, exp_wr_addr;
    int rv_seen, rv_at, cnt;
    logic [DW-1:0] rv_data;

    //            ra rb wa wb aa ab da    db    ga gb rva rvb rd
    vt[0]  = mk(1, 0, 1, 0, 5, 0, 'h3C, 0,    1, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 0, 0, 5, 0,    0,    0, 1, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 1, 'h3C);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0);
    vt[6]  = mk(0, 1, 0, 0, 0, 1, 0,    0,    0, 1, 0, 0, 0);
    vt[7]  = mk(0, 1, 0, 0, 0, 1, 0,    0,    0, 1, 0, 0, 0);
    vt[8]  = mk(0, 1, 0, 0, 0, 1, 0,    0,    0, 1, 0, 0, 0);
    vt[9]  = mk(1, 1, 0, 0, 5, 5, 0,    0,    1, 0, 0, 1, 0);
    vt[10] = mk(1, 1, 0, 0, 5, 5, 0,    0,    0, 1, 0, 1, 0);
    vt[11] = mk(1, 1, 0, 0, 5, 5, 0,    0,    1, 0, 0, 1, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1, 0, 'h3C);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 1, 'h3C);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1, 0, 'h3C);
    vt[15] = mk(0, 1, 0, 1, 0, 2, 0,    'hA5, 0, 1, 0, 0, 0);
    vt[16] = mk(1, 0, 0, 0, 2, 0, 0,    0,    1, 0, 0, 0, 0);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1, 0, 'hA5);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 0, 0, 0);

    rst_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    clr_start = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ram_en", ram_en, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_ram_din", ram_din, 0);
    chk("reset_rvalid", {rvalid_a, rvalid_b}, 0);
    chk("reset_rdata", {rdata_a, rdata_b}, 0);
    chk("reset_clr", {clr_busy, clr_done}, 0);
    rst_n = 1'b1;

    // Directed vectors; row 0 is accepted at the first edge after reset release.
    for (int i = 0; i < 21; i++) begin
      cycle(vt[i].ra, vt[i].rb, vt[i].wa, vt[i].wb, vt[i].aa, vt[i].ab, vt[i].da, vt[i].db,
            oga, ogb, orva, orvb, ord_a, ord_b);
      chk($sformatf("vec%0d_gnt_a", i), oga, vt[i].ga);
      chk($sformatf("vec%0d_gnt_b", i), ogb, vt[i].gb);
      chk($sformatf("vec%0d_rvalid_a", i), orva, vt[i].rva);
      chk($sformatf("vec%0d_rvalid_b", i), orvb, vt[i].rvb);
      if (vt[i].rva) chk($sformatf("vec%0d_rdata_a", i), ord_a, vt[i].rd);
      if (vt[i].rvb) chk($sformatf("vec%0d_rdata_b", i), ord_b, vt[i].rd);
    end

    // Randomized traffic on a small address window to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      ra = bit'($urandom_range(0, 1)); rb = bit'($urandom_range(0, 1));
      wa = bit'($urandom_range(0, 1)); wb = bit'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 7));  ab = AW'($urandom_range(0, 7));
      da = DW'($urandom);              db = DW'($urandom);
      cycle(ra, rb, wa, wb, aa, ab, da, db, oga, ogb, orva, orvb, ord_a, ord_b);
    end
    repeat (4) cycle(0, 0, 0, 0, '0, '0, '0, '0, oga, ogb, orva, orvb, ord_a, ord_b);
    chk("random_reads_drained", rdq.size(), 0);

    // Clear sequence with a read in flight and req_a held throughout.
    cycle(1, 0, 1, 0, 6'd63, '0, 8'h77, '0, oga, ogb, orva, orvb, ord_a, ord_b);
    cycle(1, 0, 0, 0, 6'd63, '0, '0, '0, oga, ogb, orva, orvb, ord_a, ord_b);
    rdq.delete();
    clr_start = 1'b1;
    #1;
    chk("clr_start_gnt_a", gnt_a, 0);
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    n_gnt0 = 0; n_busy = 0; n_done = 0; done_at = -1; gnt_at = -1;
    n_wr = 0; wr_bad = 0; exp_wr_addr = 0; rv_seen = 0; rv_at = -1; rv_data = '0;
    for (int c = 0; c < 200 && gnt_at < 0; c++) begin
      #1;
      if (gnt_a) gnt_at = c; else n_gnt0++;
      if (clr_busy) n_busy++;
      if (clr_done) begin n_done++; done_at = c; end
      if (ram_en && ram_we) begin
        if (ram_addr !== exp_wr_addr[AW-1:0] || ram_din !== '0) wr_bad++;
        exp_wr_addr++;
        n_wr++;
      end
      if (rvalid_a) begin rv_seen++; rv_at = c; rv_data = rdata_a; end
      clr_start = (c == 20);   // restart attempt mid-clear must be ignored
      @(posedge clk);
      @(negedge clk);
    end
    clr_start = 1'b0;
    chk("clear_gnt_low_cycles", n_gnt0, 64);
    chk("clear_gnt_return_cycle", gnt_at, 64);
    chk("clear_busy_cycles", n_busy, 64);
    chk("clear_done_count", n_done, 1);
    chk("clear_done_cycle", done_at, 64);
    chk("clear_write_count", n_wr, 64);
    chk("clear_write_bad", wr_bad, 0);
    chk("preclear_read_rvalid_count", rv_seen, 1);
    chk("preclear_read_rvalid_cycle", rv_at, 1);
    chk("preclear_read_rdata", rv_data, 8'h77);

    // req_a was accepted as soon as the clear finished; its read of 63 returns zero.
    req_a = 1'b0;
    rv_seen = 0; rv_at = -1; rv_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 0) begin
        chk("postclear_ram_en", ram_en, 1);
        chk("postclear_ram_we", ram_we, 0);
        chk("postclear_ram_addr", ram_addr, 63);
      end
      if (rvalid_a) begin rv_seen++; rv_at = i; rv_data = rdata_a; end
      @(posedge clk);
      @(negedge clk);
    end
    chk("postclear_rvalid_count", rv_seen, 1);
    chk("postclear_rvalid_cycle", rv_at, 2);
    chk("postclear_rdata", rv_data, 8'h00);

    // Reset right after a read is accepted aborts its return.
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd3;
    #1;
    chk("abort_read_gnt_a", gnt_a, 1);
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_read_ram_en", ram_en, 0);
    chk("abort_read_ram_addr", ram_addr, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      #1;
      if (rvalid_a || rvalid_b) cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_read_no_rvalid", cnt, 0);

    // Reset 10 cycles into a clear aborts it.
    clr_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("midclear_busy", clr_busy, 1);
    chk("midclear_ram_en", ram_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midclear_reset_busy", clr_busy, 0);
    chk("midclear_reset_done", clr_done, 0);
    chk("midclear_reset_ram_strobes", {ram_en, ram_we}, 0);
    chk("midclear_reset_ram_addr", ram_addr, 0);
    chk("midclear_reset_ram_din", ram_din, 0);
    chk("midclear_reset_rvalid", {rvalid_a, rvalid_b}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (80) begin
      #1;
      if (clr_done || clr_busy || rvalid_a || rvalid_b || ram_en) cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("midclear_no_activity_after_release", cnt, 0);

    // Arbiter is back in its reset state: A wins the first contention.
    model_reset();
    cycle(1, 1, 0, 0, 6'd10, 6'd11, '0, '0, oga, ogb, orva, orvb, ord_a, ord_b);
    chk("after_reset_first_contention_a", oga, 1);
    for (int i = 0; i < 200; i++) begin
      ra = bit'($urandom_range(0, 1)); rb = bit'($urandom_range(0, 1));
      wa = bit'($urandom_range(0, 1)); wb = bit'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 63)); ab = AW'($urandom_range(0, 63));
      da = DW'($urandom);              db = DW'($urandom);
      cycle(ra, rb, wa, wb, aa, ab, da, db, oga, ogb, orva, orvb, ord_a, ord_b);
    end
    repeat (4) cycle(0, 0, 0, 0, '0, '0, '0, '0, oga, ogb, orva, orvb, ord_a, ord_b);
    chk("final_reads_drained", rdq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
